// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// default register-address width and counter widths.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_FLUSH      = 2'd2,
        ST_MEM_WAIT   = 2'd3
    } ctrl_state_t;

    localparam int REG_W_DEF = 5;
    localparam int PERF_W    = 16;
    localparam int CNT_W     = 3;
    localparam int TIMER_W   = 8;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare: a load in EX whose destination feeds the
// instruction currently in ID. Register 0 never creates a dependency.
module hazard_detect
    import pipe_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
) (
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    output logic             hz
);

    // Hazard when the EX load writes a non-zero register read by ID
    always_comb begin
        hz = ex_mem_read && (ex_rt != '0) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Priority: data-memory wait, then taken-branch flush, then load-use stall.
// Outputs are combinational from state and inputs for zero-latency response.
// Optional build macro PIPE_CTRL_PERF_EN adds 16-bit saturating performance
// counters perf_stall, perf_flush and perf_wait.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned BR_PENALTY  = 1,
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int          REG_W       = REG_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic              id_uses_rt,
    input  logic              ex_mem_read,
    input  logic [REG_W-1:0]  ex_rt,
    input  logic              mem_branch_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              id_ex_disable,
    output logic              ex_mem_disable,
    output logic              pipe_freeze,
    output logic              mem_err,
    output logic [1:0]        ctrl_state
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_stall,
    output logic [PERF_W-1:0] perf_flush,
    output logic [PERF_W-1:0] perf_wait
`endif
);

    ctrl_state_t        state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [TIMER_W-1:0] timer, timer_sat;
    logic               timer_clr, timer_inc;
    logic               stall_hit;
    logic               hz;
    logic               wait_req;
    logic               apply_run, hz_en;

    hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .hz          (hz)
    );

    // Saturating timer increment value
    always_comb begin
        timer_sat = (timer == '1) ? timer : timer + TIMER_W'(1);
    end

    // Output decode and next-state logic; RUN rules are shared by RUN,
    // LOAD_STALL (without hazard detection) and the MEM_WAIT release cycle
    always_comb begin
        pc_write       = 1'b1;
        if_id_write    = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_disable  = 1'b0;
        ex_mem_disable = 1'b0;
        pipe_freeze    = 1'b0;
        state_nx       = state;
        cnt_nx         = cnt;
        timer_clr      = 1'b0;
        timer_inc      = 1'b0;
        stall_hit      = 1'b0;
        apply_run      = 1'b0;
        hz_en          = 1'b0;
        wait_req       = mem_req && !mem_ready;

        case (state)
            ST_RUN: begin
                apply_run = 1'b1;
                hz_en     = 1'b1;
            end
            ST_LOAD_STALL: begin
                apply_run = 1'b1;
            end
            ST_FLUSH: begin
                if (wait_req) begin
                    // Memory wait freezes everything; the flush count holds
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    pipe_freeze = 1'b1;
                end else begin
                    if_id_flush = 1'b1;
                    if (cnt <= CNT_W'(1)) begin
                        state_nx = ST_RUN;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt - CNT_W'(1);
                    end
                end
            end
            ST_MEM_WAIT: begin
                if (!mem_ready) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    pipe_freeze = 1'b1;
                    timer_inc   = 1'b1;
                end else begin
                    apply_run = 1'b1;
                    hz_en     = 1'b1;
                end
            end
            default: begin
                state_nx = ST_RUN;
            end
        endcase

        if (apply_run) begin
            state_nx = ST_RUN;
            if (wait_req) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                pipe_freeze = 1'b1;
                state_nx    = ST_MEM_WAIT;
                timer_clr   = 1'b1;
            end else if (mem_branch_taken) begin
                // Flush kills the hazarding instruction, so no stall follows
                if_id_flush    = 1'b1;
                id_ex_disable  = 1'b1;
                ex_mem_disable = 1'b1;
                pc_write       = 1'b1;
                if (BR_PENALTY > 0) begin
                    state_nx = ST_FLUSH;
                    cnt_nx   = CNT_W'(BR_PENALTY);
                end
            end else if (hz && hz_en) begin
                pc_write      = 1'b0;
                if_id_write   = 1'b0;
                id_ex_disable = 1'b1;
                state_nx      = ST_LOAD_STALL;
                stall_hit     = 1'b1;
            end
        end

        if (!rst_n) begin
            pc_write       = 1'b0;
            if_id_write    = 1'b0;
            if_id_flush    = 1'b1;
            id_ex_disable  = 1'b1;
            ex_mem_disable = 1'b1;
            pipe_freeze    = 1'b0;
            stall_hit      = 1'b0;
        end
    end

    // State, flush counter, wait timer and sticky timeout flag; mem_err is
    // set on the edge at which the wait timer reaches MEM_TIMEOUT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_RUN;
            cnt     <= '0;
            timer   <= '0;
            mem_err <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (timer_clr) begin
                timer <= '0;
            end else if (timer_inc) begin
                timer <= timer_sat;
            end
            if (timer_inc && (32'(timer_sat) >= MEM_TIMEOUT)) begin
                mem_err <= 1'b1;
            end
        end
    end

    // Current state exported for observation
    always_comb begin
        ctrl_state = state;
    end

`ifdef PIPE_CTRL_PERF_EN
    function automatic logic [PERF_W-1:0] perf_inc(input logic [PERF_W-1:0] v);
        return (v == '1) ? v : v + PERF_W'(1);
    endfunction

    // Saturating event counters for stall, flush and freeze cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall <= '0;
            perf_flush <= '0;
            perf_wait  <= '0;
        end else begin
            if (stall_hit)   perf_stall <= perf_inc(perf_stall);
            if (if_id_flush) perf_flush <= perf_inc(perf_flush);
            if (pipe_freeze) perf_wait  <= perf_inc(perf_wait);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. Instance a uses BR_PENALTY=2 and the
// default timeout; instance b uses MEM_TIMEOUT=3 for the timeout sequence.
module tb_pipe_hazard_ctrl;
    import pipe_pkg::*;

    localparam int REG_W = 5;

    // Output groups: {pc_write, if_id_write, if_id_flush, id_ex_disable, ex_mem_disable, pipe_freeze}
    localparam logic [5:0] O_DEF   = 6'b110000;
    localparam logic [5:0] O_STALL = 6'b000100;
    localparam logic [5:0] O_BR    = 6'b111110;
    localparam logic [5:0] O_FLS   = 6'b111000;
    localparam logic [5:0] O_WAIT  = 6'b000001;
    localparam logic [5:0] O_RST   = 6'b001110;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [REG_W-1:0] id_rs, id_rt, ex_rt;
    logic             id_uses_rt, ex_mem_read, mem_branch_taken, mem_req, mem_ready;

    logic pc_write_a, if_id_write_a, if_id_flush_a, id_ex_disable_a, ex_mem_disable_a, pipe_freeze_a, mem_err_a;
    logic pc_write_b, if_id_write_b, if_id_flush_b, id_ex_disable_b, ex_mem_disable_b, pipe_freeze_b, mem_err_b;
    logic [1:0] ctrl_state_a, ctrl_state_b;
`ifdef PIPE_CTRL_PERF_EN
    logic [PERF_W-1:0] perf_stall_a, perf_flush_a, perf_wait_a;
    logic [PERF_W-1:0] perf_stall_b, perf_flush_b, perf_wait_b;
`endif

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.BR_PENALTY(2), .MEM_TIMEOUT(255), .REG_W(REG_W)) dut_a (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .mem_branch_taken(mem_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write_a), .if_id_write(if_id_write_a), .if_id_flush(if_id_flush_a),
        .id_ex_disable(id_ex_disable_a), .ex_mem_disable(ex_mem_disable_a),
        .pipe_freeze(pipe_freeze_a), .mem_err(mem_err_a), .ctrl_state(ctrl_state_a)
`ifdef PIPE_CTRL_PERF_EN
        , .perf_stall(perf_stall_a), .perf_flush(perf_flush_a), .perf_wait(perf_wait_a)
`endif
    );

    pipe_hazard_ctrl #(.BR_PENALTY(1), .MEM_TIMEOUT(3), .REG_W(REG_W)) dut_b (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .mem_branch_taken(mem_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write_b), .if_id_write(if_id_write_b), .if_id_flush(if_id_flush_b),
        .id_ex_disable(id_ex_disable_b), .ex_mem_disable(ex_mem_disable_b),
        .pipe_freeze(pipe_freeze_b), .mem_err(mem_err_b), .ctrl_state(ctrl_state_b)
`ifdef PIPE_CTRL_PERF_EN
        , .perf_stall(perf_stall_b), .perf_flush(perf_flush_b), .perf_wait(perf_wait_b)
`endif
    );

    logic [8:0] obs_a, obs_b;
    assign obs_a = {pc_write_a, if_id_write_a, if_id_flush_a, id_ex_disable_a, ex_mem_disable_a,
                    pipe_freeze_a, mem_err_a, ctrl_state_a};
    assign obs_b = {pc_write_b, if_id_write_b, if_id_flush_b, id_ex_disable_b, ex_mem_disable_b,
                    pipe_freeze_b, mem_err_b, ctrl_state_b};

    typedef struct {
        string      tag;
        bit         use_b;
        logic [8:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Push the expectation for the inputs just driven, sample mid-cycle,
    // pop and compare, then advance to the next negedge.
    task automatic chk(input string tag, input bit use_b, input logic [5:0] o,
                       input logic e, input logic [1:0] s);
        exp_t       item;
        logic [8:0] got;
        item.tag   = tag;
        item.use_b = use_b;
        item.exp   = {o, e, s};
        exp_q.push_back(item);
        #2;
        item = exp_q.pop_front();
        got  = item.use_b ? obs_b : obs_a;
        vectors++;
        assert (got === item.exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", item.tag, got, item.exp);
        end
        @(negedge clk);
    endtask

    task automatic set_in(input logic mrd, input logic [REG_W-1:0] ert, input logic [REG_W-1:0] rs,
                          input logic [REG_W-1:0] rt, input logic urt, input logic br,
                          input logic req, input logic rdy);
        ex_mem_read      = mrd;
        ex_rt            = ert;
        id_rs            = rs;
        id_rt            = rt;
        id_uses_rt       = urt;
        mem_branch_taken = br;
        mem_req          = req;
        mem_ready        = rdy;
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset values before any clock edge
        chk("reset_a", 1'b0, O_RST, 1'b0, 2'd0);
        rst_n = 1'b1;
        chk("idle", 1'b0, O_DEF, 1'b0, 2'd0);

        // Load-use on rs, held: stall, suppressed cycle, then stall again
        set_in(1, 5, 5, 0, 0, 0, 0, 0);
        chk("lu_rs_stall", 1'b0, O_STALL, 1'b0, 2'd0);
        chk("lu_suppressed", 1'b0, O_DEF, 1'b0, 2'd1);
        chk("lu_redetect", 1'b0, O_STALL, 1'b0, 2'd0);
        // Branch arriving during LOAD_STALL still flushes
        set_in(1, 5, 5, 0, 0, 1, 0, 0);
        chk("ls_branch", 1'b0, O_BR, 1'b0, 2'd1);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        chk("ls_br_flush1", 1'b0, O_FLS, 1'b0, 2'd2);
        chk("ls_br_flush2", 1'b0, O_FLS, 1'b0, 2'd2);
        chk("ls_br_done", 1'b0, O_DEF, 1'b0, 2'd0);

        // Load-use through rt, and rt match ignored when rt is unused
        set_in(1, 7, 3, 7, 1, 0, 0, 0);
        chk("lu_rt_stall", 1'b0, O_STALL, 1'b0, 2'd0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        chk("lu_rt_after", 1'b0, O_DEF, 1'b0, 2'd1);
        set_in(1, 7, 3, 7, 0, 0, 0, 0);
        chk("rt_unused", 1'b0, O_DEF, 1'b0, 2'd0);

        // Register 0 and non-load cases never stall
        set_in(1, 0, 0, 0, 1, 0, 0, 0);
        chk("zero_reg", 1'b0, O_DEF, 1'b0, 2'd0);
        set_in(0, 5, 5, 5, 1, 0, 0, 0);
        chk("no_load", 1'b0, O_DEF, 1'b0, 2'd0);

        // Taken branch with two penalty cycles
        set_in(0, 0, 0, 0, 0, 1, 0, 0);
        chk("br_redirect", 1'b0, O_BR, 1'b0, 2'd0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        chk("br_pen1", 1'b0, O_FLS, 1'b0, 2'd2);
        chk("br_pen2", 1'b0, O_FLS, 1'b0, 2'd2);
        chk("br_done", 1'b0, O_DEF, 1'b0, 2'd0);

        // Branch and load-use together: flush wins, no LOAD_STALL
        set_in(1, 5, 5, 0, 0, 1, 0, 0);
        chk("br_lu_same", 1'b0, O_BR, 1'b0, 2'd0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        chk("br_lu_flush1", 1'b0, O_FLS, 1'b0, 2'd2);
        chk("br_lu_flush2", 1'b0, O_FLS, 1'b0, 2'd2);
        chk("br_lu_done", 1'b0, O_DEF, 1'b0, 2'd0);

        // Memory wait with a held branch: freeze 4 cycles, flush on release
        set_in(0, 0, 0, 0, 0, 1, 1, 0);
        chk("mw_enter", 1'b0, O_WAIT, 1'b0, 2'd0);
        chk("mw_hold1", 1'b0, O_WAIT, 1'b0, 2'd3);
        chk("mw_hold2", 1'b0, O_WAIT, 1'b0, 2'd3);
        chk("mw_hold3", 1'b0, O_WAIT, 1'b0, 2'd3);
        set_in(0, 0, 0, 0, 0, 1, 1, 1);
        chk("mw_release_br", 1'b0, O_BR, 1'b0, 2'd3);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        chk("mw_br_flush1", 1'b0, O_FLS, 1'b0, 2'd2);
        chk("mw_br_flush2", 1'b0, O_FLS, 1'b0, 2'd2);
        chk("mw_br_done", 1'b0, O_DEF, 1'b0, 2'd0);

        // Clean start for the timeout instance
        rst_n = 1'b0;
        chk("reset_b", 1'b1, O_RST, 1'b0, 2'd0);
        rst_n = 1'b1;
        chk("b_idle", 1'b1, O_DEF, 1'b0, 2'd0);

        // Timeout: mem_err rises after the third MEM_WAIT cycle and sticks
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        chk("to_enter", 1'b1, O_WAIT, 1'b0, 2'd0);
        chk("to_wait1", 1'b1, O_WAIT, 1'b0, 2'd3);
        chk("to_wait2", 1'b1, O_WAIT, 1'b0, 2'd3);
        chk("to_wait3", 1'b1, O_WAIT, 1'b0, 2'd3);
        chk("to_err_set", 1'b1, O_WAIT, 1'b1, 2'd3);
        chk("to_err_sticky", 1'b1, O_WAIT, 1'b1, 2'd3);

        // Reset mid-wait takes effect without a clock edge
        rst_n = 1'b0;
        chk("rst_midwait_b", 1'b1, O_RST, 1'b0, 2'd0);
        chk("rst_held_a", 1'b0, O_RST, 1'b0, 2'd0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        chk("post_rst_b", 1'b1, O_DEF, 1'b0, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
